// File: rtl/speed_stats.sv
// speed_stats: trip statistics for a saturated speed stream.
// Tracks the maximum speed, a D-sample moving average (D = 2**AVG_LOG2),
// a fill flag for the averaging window and an accepted-sample counter.
// Optional feature macro: SPEED_STATS_MIN_EN adds min / min_valid outputs
// tracking the smallest nonzero accepted speed.
module speed_stats #(
  parameter int W        = 7,
  parameter int KMH_MAX  = 99,
  parameter int AVG_LOG2 = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [W-1:0]     kmh,
  input  logic             clear,
  input  logic             freeze,
  output logic [W-1:0]     max,
  output logic             new_max,
  output logic [W-1:0]     avg,
  output logic             avg_full,
  output logic [CNT_W-1:0] sample_cnt
`ifdef SPEED_STATS_MIN_EN
  ,
  output logic [W-1:0]     min,
  output logic             min_valid
`endif
);

  localparam int D  = 1 << AVG_LOG2;
  localparam int SW = W + AVG_LOG2;
  localparam logic [W-1:0]        CAP      = W'(KMH_MAX);
  localparam logic [AVG_LOG2-1:0] PTR_LAST = AVG_LOG2'(D - 1);

  logic [W-1:0]        ring [D];
  logic [AVG_LOG2-1:0] ptr;
  logic [SW-1:0]       sum;

  logic [W-1:0]        s;
  logic                accept;
  logic [SW-1:0]       sum_next;

  // Saturate the input, qualify acceptance and form the next running sum.
  // The sum never underflows: it always contains the slot being replaced.
  always_comb begin
    s        = (kmh > CAP) ? CAP : kmh;
    accept   = sample_valid & ~freeze & ~clear;
    sum_next = sum - SW'(ring[ptr]) + SW'(s);
  end

  // Statistics state: async reset, synchronous clear, update on accepted samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max        <= '0;
      new_max    <= 1'b0;
      avg        <= '0;
      avg_full   <= 1'b0;
      sample_cnt <= '0;
      sum        <= '0;
      ptr        <= '0;
      for (int unsigned i = 0; i < D; i++) ring[i] <= '0;
`ifdef SPEED_STATS_MIN_EN
      min        <= CAP;
      min_valid  <= 1'b0;
`endif
    end else if (clear) begin
      max        <= '0;
      new_max    <= 1'b0;
      avg        <= '0;
      avg_full   <= 1'b0;
      sample_cnt <= '0;
      sum        <= '0;
      ptr        <= '0;
      for (int unsigned i = 0; i < D; i++) ring[i] <= '0;
`ifdef SPEED_STATS_MIN_EN
      min        <= CAP;
      min_valid  <= 1'b0;
`endif
    end else begin
      new_max <= 1'b0;
      if (accept) begin
        if (s > max) begin
          max     <= s;
          new_max <= 1'b1;
        end
        ring[ptr] <= s;
        sum       <= sum_next;
        // avg is registered from the same next-sum so it aligns with sum.
        avg       <= sum_next[SW-1:AVG_LOG2];
        ptr       <= ptr + AVG_LOG2'(1);
        // The first wrap of ptr coincides with the D-th accepted sample.
        if (ptr == PTR_LAST) avg_full <= 1'b1;
        if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
`ifdef SPEED_STATS_MIN_EN
        if (s != '0 && (s < min || !min_valid)) min <= s;
        if (s != '0) min_valid <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_speed_stats.sv
// Directed self-checking bench for speed_stats at default parameters (D=8).
module tb_speed_stats;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [6:0]  kmh = '0;
  logic        clear = 1'b0;
  logic        freeze = 1'b0;
  logic [6:0]  max;
  logic        new_max;
  logic [6:0]  avg;
  logic        avg_full;
  logic [15:0] sample_cnt;
`ifdef SPEED_STATS_MIN_EN
  logic [6:0]  min;
  logic        min_valid;
`endif

  int checks = 0;
  int errors = 0;

  speed_stats #(.W(7), .KMH_MAX(99), .AVG_LOG2(3), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .kmh(kmh),
    .clear(clear),
    .freeze(freeze),
    .max(max),
    .new_max(new_max),
    .avg(avg),
    .avg_full(avg_full),
    .sample_cnt(sample_cnt)
`ifdef SPEED_STATS_MIN_EN
    ,
    .min(min),
    .min_valid(min_valid)
`endif
  );

  always #5 clk = ~clk;

  // Present one sample across a rising edge; outputs are then 1 time unit past it.
  task automatic send(input int k);
    @(negedge clk);
    kmh = 7'(k);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (max !== 7'd0) begin errors++; $display("FAIL reset_max got %0d exp 0", max); end
    checks++; if (new_max !== 1'b0) begin errors++; $display("FAIL reset_new_max got %0b exp 0", new_max); end
    checks++; if (avg !== 7'd0) begin errors++; $display("FAIL reset_avg got %0d exp 0", avg); end
    checks++; if (avg_full !== 1'b0) begin errors++; $display("FAIL reset_avg_full got %0b exp 0", avg_full); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sample_cnt); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_max_update();
    int in_v[4]  = '{20, 35, 35, 10};
    int exp_m[4] = '{20, 35, 35, 35};
    int exp_p[4] = '{1, 1, 0, 0};
    int exp_a[4] = '{2, 6, 11, 12};
    do_clear();
    for (int i = 0; i < 4; i++) begin
      send(in_v[i]);
      checks++; if (max !== 7'(exp_m[i])) begin errors++; $display("FAIL max_upd_max[%0d] got %0d exp %0d", i, max, exp_m[i]); end
      checks++; if (new_max !== 1'(exp_p[i])) begin errors++; $display("FAIL max_upd_pulse[%0d] got %0b exp %0d", i, new_max, exp_p[i]); end
      checks++; if (avg !== 7'(exp_a[i])) begin errors++; $display("FAIL max_upd_avg[%0d] got %0d exp %0d", i, avg, exp_a[i]); end
      checks++; if (sample_cnt !== 16'(i + 1)) begin errors++; $display("FAIL max_upd_cnt[%0d] got %0d exp %0d", i, sample_cnt, i + 1); end
    end
    @(posedge clk); #1;
    checks++; if (new_max !== 1'b0) begin errors++; $display("FAIL max_upd_idle_pulse got %0b exp 0", new_max); end
  endtask

  task automatic test_saturation();
    do_clear();
    send(120);
    checks++; if (max !== 7'd99) begin errors++; $display("FAIL sat_max got %0d exp 99", max); end
    checks++; if (avg !== 7'd12) begin errors++; $display("FAIL sat_avg got %0d exp 12", avg); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt got %0d exp 1", sample_cnt); end
    checks++; if (new_max !== 1'b1) begin errors++; $display("FAIL sat_pulse got %0b exp 1", new_max); end
    send(99);
    checks++; if (max !== 7'd99) begin errors++; $display("FAIL sat_eq_max got %0d exp 99", max); end
    checks++; if (new_max !== 1'b0) begin errors++; $display("FAIL sat_eq_pulse got %0b exp 0", new_max); end
    checks++; if (avg !== 7'd24) begin errors++; $display("FAIL sat_eq_avg got %0d exp 24", avg); end
  endtask

  task automatic test_window();
    do_clear();
    for (int i = 1; i <= 8; i++) begin
      send(40);
      checks++; if (avg !== 7'(5 * i)) begin errors++; $display("FAIL win_fill_avg[%0d] got %0d exp %0d", i, avg, 5 * i); end
      checks++; if (avg_full !== (i == 8)) begin errors++; $display("FAIL win_fill_full[%0d] got %0b exp %0b", i, avg_full, i == 8); end
    end
    for (int j = 1; j <= 8; j++) begin
      send(0);
      checks++; if (avg !== 7'(40 - 5 * j)) begin errors++; $display("FAIL win_drain_avg[%0d] got %0d exp %0d", j, avg, 40 - 5 * j); end
      checks++; if (max !== 7'd40) begin errors++; $display("FAIL win_drain_max[%0d] got %0d exp 40", j, max); end
      checks++; if (avg_full !== 1'b1) begin errors++; $display("FAIL win_drain_full[%0d] got %0b exp 1", j, avg_full); end
    end
    checks++; if (sample_cnt !== 16'd16) begin errors++; $display("FAIL win_cnt got %0d exp 16", sample_cnt); end
  endtask

  task automatic test_clear_precedence();
    send(45);
    @(negedge clk);
    clear = 1'b1;
    sample_valid = 1'b1;
    kmh = 7'd50;
    @(posedge clk); #1;
    clear = 1'b0;
    sample_valid = 1'b0;
    checks++; if (max !== 7'd0) begin errors++; $display("FAIL clr_max got %0d exp 0", max); end
    checks++; if (new_max !== 1'b0) begin errors++; $display("FAIL clr_pulse got %0b exp 0", new_max); end
    checks++; if (avg !== 7'd0) begin errors++; $display("FAIL clr_avg got %0d exp 0", avg); end
    checks++; if (avg_full !== 1'b0) begin errors++; $display("FAIL clr_full got %0b exp 0", avg_full); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", sample_cnt); end
    // Cleared buffer: a single 16 must average to exactly 2.
    send(16);
    checks++; if (avg !== 7'd2) begin errors++; $display("FAIL clr_after_avg got %0d exp 2", avg); end
  endtask

  task automatic test_freeze();
    int in_v[2] = '{60, 70};
    do_clear();
    send(30);
    @(negedge clk);
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(in_v[i]);
      checks++; if (max !== 7'd30) begin errors++; $display("FAIL frz_max[%0d] got %0d exp 30", i, max); end
      checks++; if (new_max !== 1'b0) begin errors++; $display("FAIL frz_pulse[%0d] got %0b exp 0", i, new_max); end
      checks++; if (avg !== 7'd3) begin errors++; $display("FAIL frz_avg[%0d] got %0d exp 3", i, avg); end
      checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL frz_cnt[%0d] got %0d exp 1", i, sample_cnt); end
    end
    do_clear();
    checks++; if (max !== 7'd0) begin errors++; $display("FAIL frz_clear_max got %0d exp 0", max); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL frz_clear_cnt got %0d exp 0", sample_cnt); end
    @(negedge clk);
    freeze = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 5; i++) send(40);
    checks++; if (avg !== 7'd25) begin errors++; $display("FAIL arst_pre_avg got %0d exp 25", avg); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (max !== 7'd0) begin errors++; $display("FAIL arst_max got %0d exp 0", max); end
    checks++; if (avg !== 7'd0) begin errors++; $display("FAIL arst_avg got %0d exp 0", avg); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", sample_cnt); end
    #1;
    reset = 1'b0;
    send(30);
    checks++; if (avg !== 7'd3) begin errors++; $display("FAIL arst_next_avg got %0d exp 3", avg); end
    checks++; if (max !== 7'd30) begin errors++; $display("FAIL arst_next_max got %0d exp 30", max); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL arst_next_cnt got %0d exp 1", sample_cnt); end
    checks++; if (avg_full !== 1'b0) begin errors++; $display("FAIL arst_next_full got %0b exp 0", avg_full); end
  endtask

`ifdef SPEED_STATS_MIN_EN
  task automatic test_min();
    int in_v[5]  = '{0, 25, 12, 0, 18};
    int exp_m[5] = '{99, 25, 12, 12, 12};
    int exp_v[5] = '{0, 1, 1, 1, 1};
    do_clear();
    checks++; if (min !== 7'd99) begin errors++; $display("FAIL min_clear got %0d exp 99", min); end
    for (int i = 0; i < 5; i++) begin
      send(in_v[i]);
      checks++; if (min !== 7'(exp_m[i])) begin errors++; $display("FAIL min_val[%0d] got %0d exp %0d", i, min, exp_m[i]); end
      checks++; if (min_valid !== 1'(exp_v[i])) begin errors++; $display("FAIL min_valid[%0d] got %0b exp %0d", i, min_valid, exp_v[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_max_update();
    test_saturation();
    test_window();
    test_clear_precedence();
    test_freeze();
    test_async_reset();
`ifdef SPEED_STATS_MIN_EN
    test_min();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
